// File: rtl/xbar_resp_router.sv
// Crossbar return path: forwards one request to the selected chip and routes its response back.
// Optional response timeout is enabled by defining XBAR_TIMEOUT_EN.
module xbar_resp_router #(
    parameter int NCHIP      = 4,
    parameter int SEL_W      = 6,
    parameter int TMO_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [SEL_W-1:0]      a_chip_sel,
    output logic [NCHIP-1:0]      chip_a_valid,
    input  logic [NCHIP-1:0]      chip_a_ready,
    input  logic [NCHIP-1:0]      chip_d_valid,
    input  logic [NCHIP*64-1:0]   chip_d_data,
    input  logic [NCHIP-1:0]      chip_d_error,
    output logic [NCHIP-1:0]      chip_d_ready,
    output logic                  d_valid,
    output logic [63:0]           d_data,
    output logic                  d_error,
    input  logic                  d_ready
);

    localparam int DATA_W = 64;

`ifdef XBAR_TIMEOUT_EN
    localparam int CNT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TMO_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
`endif

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [DATA_W-1:0]  resp_data;
    logic               resp_err;
    logic               a_hs;
    logic               d_hs;

    function automatic logic [NCHIP-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        logic [NCHIP-1:0] oh;
        for (int i = 0; i < NCHIP; i++) begin
            oh[i] = (s == SEL_W'(i));
        end
        return oh;
    endfunction

    // Select 0 is the null page; anything at or beyond NCHIP has no chip behind it.
    function automatic logic is_mapped(input logic [SEL_W-1:0] s);
        return (s != '0) && (s < SEL_W'(NCHIP));
    endfunction

    always_comb begin
        resp_data = '0;
        resp_err  = 1'b0;
        for (int i = 0; i < NCHIP; i++) begin
            if (sel == SEL_W'(i)) begin
                resp_data = chip_d_data[DATA_W*i +: DATA_W];
                resp_err  = chip_d_error[i];
            end
        end
    end

    // The one-hot valid/ready registers are nonzero only in REQ/WAIT, so they qualify the handshakes.
    assign a_hs = |(chip_a_valid & chip_a_ready);
    assign d_hs = |(chip_d_ready & chip_d_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            sel          <= '0;
            a_ready      <= 1'b0;
            chip_a_valid <= '0;
            chip_d_ready <= '0;
            d_valid      <= 1'b0;
            d_data       <= '0;
            d_error      <= 1'b0;
`ifdef XBAR_TIMEOUT_EN
            cnt          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (a_ready && a_valid) begin
                        a_ready <= 1'b0;
                        sel     <= a_chip_sel;
                        if (is_mapped(a_chip_sel)) begin
                            state        <= S_REQ;
                            chip_a_valid <= sel_onehot(a_chip_sel);
`ifdef XBAR_TIMEOUT_EN
                            cnt          <= '0;
`endif
                        end else begin
                            state   <= S_RESP;
                            d_valid <= 1'b1;
                            d_data  <= '0;
                            d_error <= 1'b1;
                        end
                    end else begin
                        a_ready <= 1'b1;
                    end
                end
                S_REQ, S_WAIT: begin
`ifdef XBAR_TIMEOUT_EN
                    // Saturate so a handshake exactly at the limit cannot wrap the count in WAIT.
                    if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
`endif
                    if (state == S_REQ && a_hs) begin
                        state        <= S_WAIT;
                        chip_a_valid <= '0;
                        chip_d_ready <= sel_onehot(sel);
                    end else if (state == S_WAIT && d_hs) begin
                        state        <= S_RESP;
                        chip_d_ready <= '0;
                        d_valid      <= 1'b1;
                        d_data       <= resp_data;
                        d_error      <= resp_err;
                    end
`ifdef XBAR_TIMEOUT_EN
                    else if (cnt == CNT_MAX) begin
                        state        <= S_RESP;
                        chip_a_valid <= '0;
                        chip_d_ready <= '0;
                        d_valid      <= 1'b1;
                        d_data       <= 64'hDEAD_DEAD_DEAD_DEAD;
                        d_error      <= 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (d_ready) begin
                        state   <= S_IDLE;
                        d_valid <= 1'b0;
                        a_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_resp_router.sv
// Scoreboard bench for xbar_resp_router; timeout scenarios build only with XBAR_TIMEOUT_EN.
module tb_xbar_resp_router;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid;
    logic          a_ready;
    logic [5:0]    a_chip_sel;
    logic [3:0]    chip_a_valid;
    logic [3:0]    chip_a_ready;
    logic [3:0]    chip_d_valid;
    logic [255:0]  chip_d_data;
    logic [3:0]    chip_d_error;
    logic [3:0]    chip_d_ready;
    logic          d_valid;
    logic [63:0]   d_data;
    logic          d_error;
    logic          d_ready;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;

    always #5 clk = ~clk;

    xbar_resp_router #(.NCHIP(4), .SEL_W(6), .TMO_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_chip_sel(a_chip_sel),
        .chip_a_valid(chip_a_valid), .chip_a_ready(chip_a_ready),
        .chip_d_valid(chip_d_valid), .chip_d_data(chip_d_data),
        .chip_d_error(chip_d_error), .chip_d_ready(chip_d_ready),
        .d_valid(d_valid), .d_data(d_data), .d_error(d_error), .d_ready(d_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chips_idle();
        chip_a_ready = '0;
        chip_d_valid = '0;
        chip_d_data  = '0;
        chip_d_error = '0;
    endtask

    // Holds a_valid until accepted; returns in the first cycle after acceptance.
    task automatic issue(input logic [5:0] s, input int budget, output bit ok);
        logic acc;
        ok         = 1'b0;
        a_valid    = 1'b1;
        a_chip_sel = s;
        for (int k = 0; k < budget; k++) begin
            acc = a_ready;
            step();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        a_valid = 1'b0;
    endtask

    task automatic wait_d(input int budget, inout int lat, inout logic [3:0] seen);
        while (!d_valid && lat < budget) begin
            seen |= chip_a_valid;
            step();
            lat++;
        end
        seen |= chip_a_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_valid = 1'b0; a_chip_sel = '0; d_ready = 1'b0;
        chips_idle();
        step(); step();
        total_cnt++;
        if ({a_ready, chip_a_valid, chip_d_ready, d_valid, d_error} !== 11'b0 || d_data !== 64'h0)
            $display("FAIL reset_outputs: got a_ready=%b cav=%b cdr=%b dv=%b de=%b dd=%h want all 0",
                     a_ready, chip_a_valid, chip_d_ready, d_valid, d_error, d_data);
        else pass_cnt++;
        rst = 1'b0;
        step();
        total_cnt++;
        if (a_ready !== 1'b1) $display("FAIL reset_release_a_ready: got %b want 1", a_ready);
        else pass_cnt++;
    endtask

    task automatic test_mapped();
        bit ok; int lat; logic [3:0] seen; resp_t e;
        chips_idle();
        chip_a_ready = 4'b1000; chip_d_valid = 4'b1000;
        chip_d_data[255:192] = 64'h1122334455667788;
        d_ready = 1'b1;
        exp_q.push_back({64'h1122334455667788, 1'b0});
        issue(6'd3, 10, ok);
        total_cnt++;
        if (!ok) $display("FAIL mapped_accept: got not accepted want accepted");
        else pass_cnt++;
        total_cnt++;
        if (a_ready !== 1'b0) $display("FAIL mapped_a_ready_busy: got %b want 0", a_ready);
        else pass_cnt++;
        lat = 1; seen = '0;
        wait_d(20, lat, seen);
        total_cnt++;
        if (lat !== 3 || d_valid !== 1'b1) $display("FAIL mapped_latency: got %0d (dv=%b) want 3", lat, d_valid);
        else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++;
        if (d_data !== e.data || d_error !== e.err)
            $display("FAIL mapped_resp: got %h/%b want %h/%b", d_data, d_error, e.data, e.err);
        else pass_cnt++;
        total_cnt++;
        if (seen !== 4'b1000) $display("FAIL mapped_onehot: got %b want 1000", seen);
        else pass_cnt++;
        step();
        total_cnt++;
        if (a_ready !== 1'b1 || d_valid !== 1'b0)
            $display("FAIL mapped_return_idle: got a_ready=%b dv=%b want 1/0", a_ready, d_valid);
        else pass_cnt++;
        chips_idle();
    endtask

    task automatic test_null_page();
        logic [5:0] sels [3];
        bit ok; int lat; logic [3:0] seen; resp_t e;
        sels[0] = 6'd0; sels[1] = 6'd4; sels[2] = 6'd63;
        chips_idle();
        chip_a_ready = 4'b1111; chip_d_valid = 4'b1111;
        chip_d_data = {4{64'h5555_AAAA_5555_AAAA}};
        d_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({64'h0, 1'b1});
            issue(sels[i], 10, ok);
            lat = 1; seen = '0;
            wait_d(20, lat, seen);
            total_cnt++;
            if (!ok || lat !== 1 || d_valid !== 1'b1)
                $display("FAIL null_latency sel=%0d: got %0d (ok=%b dv=%b) want 1", sels[i], lat, ok, d_valid);
            else pass_cnt++;
            e = exp_q.pop_front();
            total_cnt++;
            if (d_data !== e.data || d_error !== e.err || seen !== 4'b0000)
                $display("FAIL null_resp sel=%0d: got %h/%b cav=%b want %h/%b cav=0000",
                         sels[i], d_data, d_error, seen, e.data, e.err);
            else pass_cnt++;
            step();
        end
        chips_idle();
    endtask

    task automatic test_backpressure();
        bit ok; int held; resp_t e;
        chips_idle();
        chip_d_valid = 4'b0010;
        chip_d_data[127:64] = 64'h0102_0304_0506_0708;
        chip_d_error = 4'b0010;
        d_ready = 1'b0;
        exp_q.push_back({64'h0102_0304_0506_0708, 1'b1});
        issue(6'd1, 10, ok);
        held = 0;
        for (int k = 0; k < 6; k++) begin
            if (chip_a_valid === 4'b0010) held++;
            if (k == 5) chip_a_ready = 4'b0010;
            step();
        end
        chip_a_ready = '0;
        total_cnt++;
        if (!ok || held !== 6) $display("FAIL bp_a_valid_hold: got %0d cycles want 6", held);
        else pass_cnt++;
        total_cnt++;
        if (chip_a_valid !== 4'b0000 || chip_d_ready !== 4'b0010 || d_valid !== 1'b0)
            $display("FAIL bp_wait_state: got cav=%b cdr=%b dv=%b want 0000/0010/0", chip_a_valid, chip_d_ready, d_valid);
        else pass_cnt++;
        step();
        chip_d_valid = '0;
        chip_d_data  = {4{64'hFFFF_0000_FFFF_0000}};
        chip_d_error = '0;
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            total_cnt++;
            if (d_valid !== 1'b1 || d_data !== e.data || d_error !== e.err || a_ready !== 1'b0)
                $display("FAIL bp_hold_%0d: got dv=%b %h/%b a_ready=%b want 1 %h/%b 0",
                         k, d_valid, d_data, d_error, a_ready, e.data, e.err);
            else pass_cnt++;
            step();
        end
        d_ready = 1'b1;
        step();
        total_cnt++;
        if (a_ready !== 1'b1 || d_valid !== 1'b0)
            $display("FAIL bp_after_hs: got a_ready=%b dv=%b want 1/0", a_ready, d_valid);
        else pass_cnt++;
        chips_idle();
    endtask

    task automatic test_stray();
        bit ok; int lat; logic [3:0] seen; resp_t e;
        chips_idle();
        chip_a_ready = 4'b0100;
        chip_d_valid = 4'b0010;
        chip_d_data[127:64] = 64'hBAD;
        d_ready = 1'b1;
        exp_q.push_back({64'hCAFE_F00D_0000_0002, 1'b0});
        issue(6'd2, 10, ok);
        step();
        total_cnt++;
        if (!ok || chip_d_ready !== 4'b0100)
            $display("FAIL stray_d_ready: got %b want 0100", chip_d_ready);
        else pass_cnt++;
        step(); step();
        total_cnt++;
        if (d_valid !== 1'b0 || chip_d_ready !== 4'b0100)
            $display("FAIL stray_ignored: got dv=%b cdr=%b want 0/0100", d_valid, chip_d_ready);
        else pass_cnt++;
        chip_d_valid = 4'b0110;
        chip_d_data[191:128] = 64'hCAFE_F00D_0000_0002;
        lat = 0; seen = '0;
        wait_d(10, lat, seen);
        e = exp_q.pop_front();
        total_cnt++;
        if (d_valid !== 1'b1 || d_data !== e.data || d_error !== e.err)
            $display("FAIL stray_resp: got dv=%b %h/%b want 1 %h/%b", d_valid, d_data, d_error, e.data, e.err);
        else pass_cnt++;
        step();
        chips_idle();
    endtask

    task automatic test_reset_mid_wait();
        bit ok; int lat; logic [3:0] seen; resp_t e;
        chips_idle();
        chip_a_ready = 4'b0010;
        d_ready = 1'b1;
        issue(6'd1, 10, ok);
        step();
        total_cnt++;
        if (!ok || chip_d_ready !== 4'b0010) $display("FAIL rst_pre_wait: got cdr=%b want 0010", chip_d_ready);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({a_ready, chip_a_valid, chip_d_ready, d_valid, d_error} !== 11'b0 || d_data !== 64'h0)
            $display("FAIL rst_async_outputs: got a_ready=%b cav=%b cdr=%b dv=%b dd=%h want all 0",
                     a_ready, chip_a_valid, chip_d_ready, d_valid, d_data);
        else pass_cnt++;
        chip_d_valid = 4'b0010;
        chip_d_data[127:64] = 64'h7777_6666_5555_4444;
        step();
        rst = 1'b0;
        step(); step();
        total_cnt++;
        if (d_valid !== 1'b0 || a_ready !== 1'b1)
            $display("FAIL rst_dropped: got dv=%b a_ready=%b want 0/1", d_valid, a_ready);
        else pass_cnt++;
        exp_q.push_back({64'h7777_6666_5555_4444, 1'b0});
        issue(6'd1, 10, ok);
        lat = 1; seen = '0;
        wait_d(20, lat, seen);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || lat !== 3 || d_data !== e.data || d_error !== e.err)
            $display("FAIL rst_new_req: got lat=%0d %h/%b want 3 %h/%b", lat, d_data, d_error, e.data, e.err);
        else pass_cnt++;
        step();
        chips_idle();
    endtask

`ifdef XBAR_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; int lat; logic [3:0] seen; resp_t e;
        chips_idle();
        chip_a_ready = 4'b0100;
        d_ready = 1'b1;
        exp_q.push_back({64'hDEAD_DEAD_DEAD_DEAD, 1'b1});
        issue(6'd2, 10, ok);
        lat = 1; seen = '0;
        wait_d(40, lat, seen);
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || lat !== 17 || d_data !== e.data || d_error !== e.err || chip_d_ready !== 4'b0)
            $display("FAIL tmo_fire: got lat=%0d %h/%b cdr=%b want 17 %h/%b 0000",
                     lat, d_data, d_error, chip_d_ready, e.data, e.err);
        else pass_cnt++;
        step();
        exp_q.push_back({64'h0BAD_C0DE_0000_0016, 1'b0});
        chip_d_data[191:128] = 64'h0BAD_C0DE_0000_0016;
        issue(6'd2, 10, ok);
        lat = 1;
        while (lat < 16) begin
            step();
            lat++;
        end
        chip_d_valid = 4'b0100;
        step();
        chip_d_valid = '0;
        e = exp_q.pop_front();
        total_cnt++;
        if (!ok || d_valid !== 1'b1 || d_data !== e.data || d_error !== e.err)
            $display("FAIL tmo_last_cycle: got dv=%b %h/%b want 1 %h/%b", d_valid, d_data, d_error, e.data, e.err);
        else pass_cnt++;
        step();
        chips_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_mapped();
        test_null_page();
        test_backpressure();
        test_stray();
        test_reset_mid_wait();
`ifdef XBAR_TIMEOUT_EN
        test_timeout();
`endif
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "watchdog");
    end

endmodule
